// File: rtl/prbs_checker_if.sv
// Serial PRBS checker bus: received stream in, lock/error status out.
interface prbs_checker_if #(
  parameter int unsigned CNT_WIDTH = 16
) ();
  logic                 en;
  logic                 din;
  logic                 clr;
  logic                 locked;
  logic                 err;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic [CNT_WIDTH-1:0] bit_cnt;

  modport master (
    output en, din, clr,
    input  locked, err, err_cnt, bit_cnt
  );

  modport slave (
    input  en, din, clr,
    output locked, err, err_cnt, bit_cnt
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker. A local reference LFSR is loaded from
// the received stream while hunting and free-runs once locked; mismatches are
// counted and lock is dropped when too many errors land in one window.
module prbs_checker #(
  parameter int unsigned            WIDTH       = 7,
  parameter logic [WIDTH-1:0]       POLYNOMIAL  = 7'b1100000,
  parameter int unsigned            LOCK_COUNT  = 16,
  parameter int unsigned            WINDOW      = 64,
  parameter int unsigned            LOSS_THRESH = 8,
  parameter int unsigned            CNT_WIDTH   = 16
) (
  input logic           clk,
  input logic           reset_n,
  prbs_checker_if.slave bus
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BitsW  = $clog2(WINDOW);
  localparam int unsigned ErrW   = $clog2(LOSS_THRESH + 1);

  typedef enum logic {StHunt, StLocked} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [MatchW-1:0]    match_q, match_d;
  logic [BitsW-1:0]     win_bits_q, win_bits_d;
  logic [ErrW-1:0]      win_err_q, win_err_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic                 pred;
  logic                 err_inc;
  logic                 bit_inc;

  assign pred = ^(sr_q & POLYNOMIAL);

  // State register and all output/counter flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StHunt;
      sr_q       <= '0;
      match_q    <= '0;
      win_bits_q <= '0;
      win_err_q  <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      match_q    <= match_d;
      win_bits_q <= win_bits_d;
      win_err_q  <= win_err_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  // Acquisition / tracking FSM and window bookkeeping; en=0 holds everything.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    match_d    = match_q;
    win_bits_d = win_bits_q;
    win_err_d  = win_err_q;
    err_d      = 1'b0;
    err_inc    = 1'b0;
    bit_inc    = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        StHunt: begin
          sr_d = {sr_q[WIDTH-2:0], bus.din};
          // An all-zero reference predicts 0 forever, so its matches never count.
          if (sr_q != '0 && bus.din == pred) begin
            if (match_q == MatchW'(LOCK_COUNT - 1)) begin
              state_d    = StLocked;
              match_d    = '0;
              win_bits_d = '0;
              win_err_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          bit_inc = 1'b1;
          err_inc = (bus.din != pred);
          err_d   = err_inc;
          // Loss is decided before the window can wrap, so a final-bit error
          // still counts against the window it belongs to.
          if (err_inc && win_err_q == ErrW'(LOSS_THRESH - 1)) begin
            state_d = StHunt;
            match_d = '0;
          end else begin
            sr_d = {sr_q[WIDTH-2:0], pred};
            if (win_bits_q == BitsW'(WINDOW - 1)) begin
              win_bits_d = '0;
              win_err_d  = '0;
            end else begin
              win_bits_d = win_bits_q + 1'b1;
              win_err_d  = win_err_q + ErrW'(err_inc);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating event counters; clr wins over a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (bus.clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      if (err_inc && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (bit_inc && bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  assign bus.locked  = (state_q == StLocked);
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (16-bit and 4-bit counters) share one
// stimulus stream and are compared against a queue-based reference model.
module tb_prbs_checker;

  localparam int unsigned WIDTH      = 7;
  localparam int unsigned LOCK_COUNT = 16;
  localparam int unsigned WINDOW     = 64;
  localparam int unsigned LOSS       = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;

  int total = 0;
  int bad = 0;

  prbs_checker_if #(.CNT_WIDTH(16)) bus16 ();
  prbs_checker_if #(.CNT_WIDTH(4))  bus4 ();

  assign bus16.en  = en;
  assign bus16.din = din;
  assign bus16.clr = clr;
  assign bus4.en   = en;
  assign bus4.din  = din;
  assign bus4.clr  = clr;

  prbs_checker #(.CNT_WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));
  prbs_checker #(.CNT_WIDTH(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(bus4));

  always #5 clk = ~clk;

  // Upstream generator: b[n] = XOR of taps over previous bits.
  logic [WIDTH-1:0] taps = 7'b1100000;
  logic [WIDTH-1:0] gen_sr = 7'h5B;

  task automatic gen_next(output bit b);
    b = ^(gen_sr & taps);
    gen_sr = {gen_sr[WIDTH-2:0], b};
  endtask

  // Reference model: ref_q[0] is the most recent reference bit.
  bit ref_q[$];
  bit m_locked, m_err;
  int m_match, m_wbits, m_werr;
  int m_ec16, m_bc16, m_ec4, m_bc4;

  task automatic model_reset();
    ref_q = {};
    for (int i = 0; i < WIDTH; i++) ref_q.push_back(1'b0);
    m_locked = 0; m_err = 0; m_match = 0; m_wbits = 0; m_werr = 0;
    m_ec16 = 0; m_bc16 = 0; m_ec4 = 0; m_bc4 = 0;
  endtask

  task automatic model_step(input bit e, input bit d, input bit c);
    bit p, nz, cnt_err, cnt_bit;
    p = 0; nz = 0; cnt_err = 0; cnt_bit = 0;
    m_err = 0;
    if (e) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (taps[i]) p ^= ref_q[i];
        nz |= ref_q[i];
      end
      if (!m_locked) begin
        m_match = (nz && d == p) ? m_match + 1 : 0;
        ref_q.push_front(d);
        void'(ref_q.pop_back());
        if (m_match == LOCK_COUNT) begin
          m_locked = 1; m_match = 0; m_wbits = 0; m_werr = 0;
        end
      end else begin
        cnt_bit = 1;
        cnt_err = (d != p);
        m_err = cnt_err;
        if (cnt_err) m_werr++;
        if (m_werr == LOSS) begin
          m_locked = 0; m_match = 0;
        end else begin
          ref_q.push_front(p);
          void'(ref_q.pop_back());
          m_wbits++;
          if (m_wbits == WINDOW) begin m_wbits = 0; m_werr = 0; end
        end
      end
    end
    if (c) begin
      m_ec16 = 0; m_bc16 = 0; m_ec4 = 0; m_bc4 = 0;
    end else begin
      if (cnt_err && m_ec16 < 65535) m_ec16++;
      if (cnt_bit && m_bc16 < 65535) m_bc16++;
      if (cnt_err && m_ec4 < 15) m_ec4++;
      if (cnt_bit && m_bc4 < 15) m_bc4++;
    end
  endtask

  task automatic tick(input bit e, input bit d, input bit c);
    en = e; din = d; clr = c;
    model_step(e, d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit e, input bit flip, input bit c);
    bit b;
    if (e) begin
      gen_next(b);
      b = b ^ flip;
    end else begin
      b = 1'($urandom);
    end
    tick(e, b, c);
  endtask

  task automatic do_reset();
    en = 0; din = 0; clr = 0;
    #2 reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic acquire(output int n);
    n = 0;
    while (n < 40 && bus16.locked !== 1'b1) begin
      send(1, 0, 0);
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus16.locked !== 1'b0 || bus16.err !== 1'b0 || bus16.err_cnt !== 16'd0 ||
        bus16.bit_cnt !== 16'd0 || bus4.err_cnt !== 4'd0 || bus4.bit_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset: locked=%b err=%b ec=%0d bc=%0d, want all 0",
               bus16.locked, bus16.err, bus16.err_cnt, bus16.bit_cnt);
    end
  endtask

  task automatic test_clean_lock();
    int n, errs;
    do_reset();
    gen_sr = 7'h5B;
    acquire(n);
    total++;
    if (bus16.locked !== 1'b1 || n > WIDTH + LOCK_COUNT) begin
      bad++;
      $display("FAIL clean_lock: locked=%b after %0d en cycles, want 1 within 23",
               bus16.locked, n);
    end
    errs = 0;
    for (int k = 0; k < 1000; k++) begin
      send(1, 0, 0);
      if (bus16.err !== 1'b0) errs++;
    end
    total++;
    if (errs != 0 || bus16.err_cnt !== 16'd0 || bus16.locked !== 1'b1) begin
      bad++;
      $display("FAIL clean_run: err pulses=%0d ec=%0d locked=%b, want 0 0 1",
               errs, bus16.err_cnt, bus16.locked);
    end
    total++;
    if (bus16.bit_cnt !== 16'd1000 || bus4.bit_cnt !== 4'd15) begin
      bad++;
      $display("FAIL clean_bitcnt: bc=%0d bc4=%0d, want 1000 15", bus16.bit_cnt, bus4.bit_cnt);
    end
  endtask

  task automatic test_single_error();
    int n, errs;
    do_reset();
    gen_sr = 7'($urandom_range(1, 127));
    acquire(n);
    repeat (10) send(1, 0, 0);
    send(1, 1, 0);
    total++;
    if (bus16.err !== 1'b1 || bus16.err_cnt !== 16'd1 || bus16.locked !== 1'b1) begin
      bad++;
      $display("FAIL single_err: err=%b ec=%0d locked=%b, want 1 1 1",
               bus16.err, bus16.err_cnt, bus16.locked);
    end
    errs = 0;
    for (int k = 0; k < 200; k++) begin
      send(1, 0, 0);
      if (bus16.err !== 1'b0) errs++;
    end
    total++;
    if (errs != 0 || bus16.err_cnt !== 16'd1 || bus16.locked !== 1'b1) begin
      bad++;
      $display("FAIL single_noprop: pulses=%0d ec=%0d locked=%b, want 0 1 1",
               errs, bus16.err_cnt, bus16.locked);
    end
  endtask

  task automatic test_loss();
    int n;
    do_reset();
    gen_sr = 7'($urandom_range(1, 127));
    acquire(n);
    repeat (2) send(1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      send(1, 1, 0);
      repeat (2) send(1, 0, 0);
    end
    total++;
    if (bus16.locked !== 1'b1 || bus16.err_cnt !== 16'd7) begin
      bad++;
      $display("FAIL loss_pre: locked=%b ec=%0d, want 1 7", bus16.locked, bus16.err_cnt);
    end
    send(1, 1, 0);
    total++;
    if (bus16.locked !== 1'b0 || bus16.err !== 1'b1 || bus16.err_cnt !== 16'd8) begin
      bad++;
      $display("FAIL loss_drop: locked=%b err=%b ec=%0d, want 0 1 8",
               bus16.locked, bus16.err, bus16.err_cnt);
    end
    acquire(n);
    total++;
    if (bus16.locked !== 1'b1 || n > WIDTH + LOCK_COUNT || bus16.err_cnt !== 16'd8) begin
      bad++;
      $display("FAIL loss_relock: locked=%b n=%0d ec=%0d, want 1 <=23 8",
               bus16.locked, n, bus16.err_cnt);
    end
  endtask

  task automatic test_window_boundary();
    int n, drops;
    do_reset();
    gen_sr = 7'($urandom_range(1, 127));
    acquire(n);
    drops = 0;
    // Bits 57..63 close window 0 with 7 errors; 64..70 put 7 in window 1.
    for (int k = 0; k < 71; k++) begin
      send(1, k >= 57, 0);
      if (bus16.locked !== 1'b1) drops++;
    end
    total++;
    if (drops != 0 || bus16.err_cnt !== 16'd14) begin
      bad++;
      $display("FAIL window_split: drops=%0d ec=%0d, want 0 14", drops, bus16.err_cnt);
    end
    send(1, 1, 0);
    total++;
    if (bus16.locked !== 1'b0 || bus16.err_cnt !== 16'd15) begin
      bad++;
      $display("FAIL window_8th: locked=%b ec=%0d, want 0 15", bus16.locked, bus16.err_cnt);
    end
  endtask

  task automatic test_stuck();
    int highs;
    do_reset();
    highs = 0;
    for (int k = 0; k < 500; k++) begin
      tick(1, 0, 0);
      if (bus16.locked !== 1'b0) highs++;
    end
    total++;
    if (highs != 0 || bus16.err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL stuck0: locked-high cycles=%0d ec=%0d, want 0 0", highs, bus16.err_cnt);
    end
  endtask

  task automatic test_gaps();
    int en_cnt, lock_at, mism;
    bit e, f;
    do_reset();
    gen_sr = 7'h5B;
    en_cnt = 0; lock_at = -1; mism = 0;
    for (int k = 0; k < 800; k++) begin
      e = 1'($urandom);
      f = e && m_locked && ($urandom_range(0, 39) == 0);
      send(e, f, 0);
      if (e) en_cnt++;
      if (lock_at < 0 && bus16.locked === 1'b1) lock_at = en_cnt;
      if (bus16.locked !== m_locked || bus16.err !== m_err ||
          bus16.err_cnt !== 16'(m_ec16) || bus16.bit_cnt !== 16'(m_bc16) ||
          bus4.err_cnt !== 4'(m_ec4) || bus4.bit_cnt !== 4'(m_bc4)) mism++;
    end
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL gaps_model: %0d cycles differ from model, want 0", mism);
    end
    total++;
    if (lock_at < 0 || lock_at > WIDTH + LOCK_COUNT) begin
      bad++;
      $display("FAIL gaps_lock: locked after %0d en cycles, want 1..23", lock_at);
    end
  endtask

  task automatic test_saturation();
    int n, mism;
    bit f, c;
    do_reset();
    gen_sr = 7'($urandom_range(1, 127));
    acquire(n);
    mism = 0;
    for (int k = 0; k < 200; k++) begin
      send(1, (k % 10) == 5, 0);
      if (bus16.err !== m_err || bus16.err_cnt !== 16'(m_ec16) ||
          bus4.err_cnt !== 4'(m_ec4) || bus16.locked !== m_locked) mism++;
    end
    total++;
    if (mism != 0 || bus4.err_cnt !== 4'd15 || bus16.err_cnt !== 16'd20 ||
        bus4.bit_cnt !== 4'd15 || bus16.locked !== 1'b1) begin
      bad++;
      $display("FAIL sat: ec4=%0d ec=%0d bc4=%0d locked=%b mism=%0d, want 15 20 15 1 0",
               bus4.err_cnt, bus16.err_cnt, bus4.bit_cnt, bus16.locked, mism);
    end
    repeat (3) send(1, 0, 0);
    send(1, 1, 1);
    total++;
    if (bus16.err !== 1'b1 || bus16.err_cnt !== 16'd0 || bus4.err_cnt !== 4'd0 ||
        bus16.bit_cnt !== 16'd0) begin
      bad++;
      $display("FAIL clr_priority: err=%b ec=%0d ec4=%0d bc=%0d, want 1 0 0 0",
               bus16.err, bus16.err_cnt, bus4.err_cnt, bus16.bit_cnt);
    end
    mism = 0;
    for (int k = 0; k < 300; k++) begin
      c = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 11) == 0);
      send(1'($urandom), f, c);
      if (bus16.locked !== m_locked || bus16.err !== m_err ||
          bus16.err_cnt !== 16'(m_ec16) || bus16.bit_cnt !== 16'(m_bc16) ||
          bus4.err_cnt !== 4'(m_ec4) || bus4.bit_cnt !== 4'(m_bc4)) mism++;
    end
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL clr_random: %0d cycles differ from model, want 0", mism);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    gen_sr = 7'($urandom_range(1, 127));
    acquire(n);
    repeat (5) send(1, 0, 0);
    send(1, 1, 0);
    #2 reset_n = 0;
    #1;
    total++;
    if (bus16.locked !== 1'b0 || bus16.err !== 1'b0 || bus16.err_cnt !== 16'd0 ||
        bus16.bit_cnt !== 16'd0 || bus4.err_cnt !== 4'd0 || bus4.bit_cnt !== 4'd0) begin
      bad++;
      $display("FAIL async_reset: locked=%b err=%b ec=%0d bc=%0d, want all 0",
               bus16.locked, bus16.err, bus16.err_cnt, bus16.bit_cnt);
    end
    model_reset();
    en = 0;
    @(posedge clk);
    #1 reset_n = 1;
    acquire(n);
    total++;
    if (bus16.locked !== 1'b1 || n > WIDTH + LOCK_COUNT || bus16.err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL async_relock: locked=%b n=%0d ec=%0d, want 1 <=23 0",
               bus16.locked, n, bus16.err_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss();
    test_window_boundary();
    test_stuck();
    test_gaps();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker that consumes the single-bit output of the team's parametrised LFSR generator, or a looped-back copy of it, one bit per enabled cycle. It self-synchronises a local reference LFSR to the incoming stream and declares lock. Once locked, it compares every received bit against the reference, counts bit errors, and drops lock when the error density exceeds a threshold. It sits directly downstream of the LFSR generator in BIST/loopback paths.

## Interface
- WIDTH, 7: LFSR length; must equal the upstream generator's width (≥3)
- POLYNOMIAL, 7'b1100000: tap mask; bit i set ⇒ sr[i] enters the feedback XOR (same convention as the generator)
- LOCK_COUNT, 16: consecutive matching bits required to declare lock (1..255)
- WINDOW, 64: bits per error-density window while locked (≥2)
- LOSS_THRESH, 8: errors within one window that force loss of lock (1..WINDOW)
- CNT_WIDTH, 16: width of err_cnt and bit_cnt
- clk  in  1  clock; all logic on the rising edge
- reset_n  in  1  reset; asynchronous, active-low
- en  in  1  din is valid this cycle; the block ignores din and holds all state when low
- din  in  1  received serial bit
- clr  in  1  synchronous clear of err_cnt and bit_cnt
- locked  out  1  1 while in LOCKED
- err  out  1  one-cycle pulse per mismatched bit while locked
- err_cnt  out  CNT_WIDTH  saturating error count
- bit_cnt  out  CNT_WIDTH  saturating count of bits checked while locked

## Operation
- Reference register sr[WIDTH-1:0] shifts left: next sr = {sr[WIDTH-2:0], x}. Prediction p = XOR of sr[i] over every i with POLYNOMIAL[i]=1.
- FSM states: HUNT and LOCKED. Reset enters HUNT.
- HUNT, on each en cycle:
  - x = din, so the register fills from the received stream.
  - If sr ≠ 0 and din = p, increment match_cnt; otherwise set match_cnt to 0.
  - Matches while sr = 0 never count, so a stuck-0 line cannot lock.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED and clear the window counters.
  - err, err_cnt and bit_cnt do not change in HUNT.
- LOCKED, on each en cycle:
  - x = p, so the reference free-runs and errors do not propagate into it.
  - If din ≠ p: pulse err and increment err_cnt and win_err.
  - bit_cnt increments on every en cycle.
  - win_bits increments; when it wraps at WINDOW, win_bits and win_err return to 0.
  - If the increment of win_err brings it to LOSS_THRESH: go to HUNT, clear match_cnt, and leave sr unchanged. The next bit restarts acquisition.
- Counter widths: match_cnt is $clog2(LOCK_COUNT+1) bits, win_bits is $clog2(WINDOW) bits, win_err is $clog2(LOSS_THRESH+1) bits.
- err_cnt and bit_cnt saturate at all-ones and never wrap.
- clr has priority over increments in the same cycle: both counters become 0 and that cycle's error or bit is dropped from the counts. clr does not affect the FSM, sr or the window counters.
- An error on the bit that would complete a window is counted in the old window before the window reset. Loss is checked first.

## Timing
- All outputs are registered. Reset values: locked=0, err=0, err_cnt=0, bit_cnt=0. Internal reset values: sr=0, match_cnt=0, win_bits=0, win_err=0.
- err is high for exactly the one cycle after the en cycle holding the mismatched bit, and low otherwise (including when en=0).
- locked rises on the cycle after the LOCK_COUNT-th consecutive match, and falls on the cycle after the error that reaches LOSS_THRESH. That error still pulses err and counts in err_cnt.
- Counters update one cycle after the qualifying en cycle.
- en=0 cycles are fully transparent: no state changes.
- Asynchronous reset mid-stream returns the block to HUNT immediately. The block reacquires from scratch after release.
- Worst-case lock time on a clean stream is WIDTH + LOCK_COUNT en cycles from reset release.

## Test plan
- Clean lock (defaults): generator seeded with 7'h5B feeds din with en=1 continuously → locked=1 within 23 en cycles. Over 1000 further bits: err_cnt=0, err never pulses, bit_cnt matches the number of bits checked since lock.
- Single error: after lock, invert one bit → exactly one err pulse one cycle later, err_cnt=1, locked stays 1, and the next bits show no further errors (no propagation).
- Loss of lock: after lock, invert 8 bits within one 64-bit window → locked falls on the cycle after the 8th error with err_cnt=8. With a clean stream, locked reasserts after ≤16 matching bits and err_cnt stays 8.
- Window boundary: invert 7 bits in window N and 7 in window N+1 → locked stays 1 and err_cnt=14.
- Stuck line and gaps: din=0 constantly for 500 cycles → locked stays 0. With a clean PRBS and en toggling randomly at 50%, the lock and error results match the en=1 case.
- clr and saturation (CNT_WIDTH=4): 20 injected errors while locked → err_cnt=15 and held there. Assert clr in the same cycle as an error → err_cnt=0 next cycle. Pulse reset_n mid-stream → all outputs 0 immediately.
